osc_intl_mc: RTL and testbench

- Multi-channel, parametrised oscillation interlock for the MPS interlock cluster.
- Watches CH signed fixed-point ADC channels over a repeating window of N valid samples and computes each channel's peak-to-peak (max-min).
- Each window, a per-channel leaky counter steps up if peak-to-peak reaches that channel's threshold, otherwise steps down.
- When a channel's count reaches the count threshold, its interlock flag latches until cleared. Adds integer datapath, per-channel thresholds/enables, sample-valid qualification, continuous mode and counter saturation.

---
 rtl/osc_intl_mc.sv | 126 ++++++++++++
 tb/tb_osc_intl_mc.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/osc_intl_mc.sv
// osc_intl_mc: per-channel peak-to-peak oscillation interlock over windows of valid samples,
// with a leaky per-channel counter that latches an interlock flag on reaching the count threshold.
module osc_intl_mc #(
    parameter int CH = 4,
    parameter int DW = 20,
    parameter int CW = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [CH*DW-1:0]   i_data,
    input  logic               i_data_valid,
    input  logic [CH-1:0]      i_osc_en,
    input  logic [CH-1:0]      i_clr,
    input  logic [CH*DW-1:0]   i_data_thresh,
    input  logic [CW-1:0]      i_cnt_thresh,
    input  logic [CW-1:0]      i_period,
    input  logic [CW-1:0]      i_cycle_cnt,
    output logic [CH-1:0]      o_osc_flag,
    output logic               o_osc_any,
    output logic [1:0]         o_state,
    output logic [CH*CW-1:0]   o_osc_cnt,
    output logic [CH*(DW+1)-1:0] o_p2p
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, EVAL = 2'd2} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        sample_cnt_q, sample_cnt_d, window_cnt_q, window_cnt_d;
    logic signed [DW-1:0] min_q [CH], min_d [CH], max_q [CH], max_d [CH];
    logic [CW-1:0]        osc_cnt_q [CH], osc_cnt_d [CH];
    logic [DW:0]          p2p_q [CH], p2p_d [CH];
    logic [CH-1:0]        flag_q, flag_d;
    logic signed [DW-1:0] smp;
    logic [CW-1:0]        per, sample_nx, window_nx;
    logic                 arm;

    assign arm       = |(i_osc_en & ~flag_q);
    assign per       = (i_period == '0) ? CW'(1) : i_period;
    assign sample_nx = sample_cnt_q + CW'(1);
    assign window_nx = window_cnt_q + CW'(1);

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        window_cnt_d = window_cnt_q;
        smp          = '0;
        case (state_q)
            IDLE: begin
                sample_cnt_d = '0;
                window_cnt_d = '0;
                state_d      = arm ? RUN : IDLE;
            end
            RUN: begin
                if (!arm) state_d = IDLE;
                else if (i_data_valid) begin
                    sample_cnt_d = sample_nx;
                    state_d      = (sample_nx == per) ? EVAL : RUN;
                end
            end
            EVAL: begin
                sample_cnt_d = '0;
                window_cnt_d = window_nx;
                state_d      = ((i_cycle_cnt != '0 && window_nx == i_cycle_cnt) || !arm) ? IDLE : RUN;
            end
            default: state_d = IDLE;
        endcase
        for (int c = 0; c < CH; c++) begin
            smp          = i_data[c*DW +: DW];
            min_d[c]     = min_q[c];
            max_d[c]     = max_q[c];
            osc_cnt_d[c] = osc_cnt_q[c];
            p2p_d[c]     = p2p_q[c];
            if (state_q == IDLE) begin
                min_d[c]     = '0;
                max_d[c]     = '0;
                osc_cnt_d[c] = '0;
            end else if (state_q == RUN && i_data_valid) begin
                min_d[c] = (sample_cnt_q == '0 || smp < min_q[c]) ? smp : min_q[c];
                max_d[c] = (sample_cnt_q == '0 || smp > max_q[c]) ? smp : max_q[c];
            end else if (state_q == EVAL) begin
                // sign-extend by one bit so max-min never overflows
                p2p_d[c] = {max_q[c][DW-1], max_q[c]} - {min_q[c][DW-1], min_q[c]};
                if (i_osc_en[c] && !flag_q[c])
                    osc_cnt_d[c] = (p2p_d[c] >= {1'b0, i_data_thresh[c*DW +: DW]})
                        ? ((osc_cnt_q[c] == '1) ? osc_cnt_q[c] : osc_cnt_q[c] + CW'(1))
                        : ((osc_cnt_q[c] == '0) ? osc_cnt_q[c] : osc_cnt_q[c] - CW'(1));
            end
            if (!i_osc_en[c]) osc_cnt_d[c] = '0;
            flag_d[c] = !i_clr[c] && (flag_q[c] || (i_osc_en[c] && osc_cnt_q[c] >= i_cnt_thresh));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            sample_cnt_q <= '0;
            window_cnt_q <= '0;
            flag_q       <= '0;
            for (int c = 0; c < CH; c++) begin
                min_q[c]     <= '0;
                max_q[c]     <= '0;
                osc_cnt_q[c] <= '0;
                p2p_q[c]     <= '0;
            end
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            window_cnt_q <= window_cnt_d;
            flag_q       <= flag_d;
            for (int c = 0; c < CH; c++) begin
                min_q[c]     <= min_d[c];
                max_q[c]     <= max_d[c];
                osc_cnt_q[c] <= osc_cnt_d[c];
                p2p_q[c]     <= p2p_d[c];
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_out
        assign o_osc_cnt[g*CW +: CW]       = osc_cnt_q[g];
        assign o_p2p[g*(DW+1) +: (DW+1)]   = p2p_q[g];
    end

    assign o_osc_flag = flag_q;
    assign o_osc_any  = |flag_q;
    assign o_state    = state_q;
endmodule

// File: tb/tb_osc_intl_mc.sv
// tb_osc_intl_mc: directed-vector bench for osc_intl_mc, plus a narrow-counter instance
// used to reach counter saturation in few cycles.
module tb_osc_intl_mc;
    localparam int CH = 4;
    localparam int DW = 20;
    localparam int CW = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [CH*DW-1:0]   data;
    logic               valid;
    logic [CH-1:0]      en, clr;
    logic [CH*DW-1:0]   thr;
    logic [CW-1:0]      cnt_thr, period, cycle;
    logic [CH-1:0]      flag;
    logic               any;
    logic [1:0]         state;
    logic [CH*CW-1:0]   cnt;
    logic [CH*(DW+1)-1:0] p2p;

    logic [DW-1:0]      s_data;
    logic               s_valid;
    logic [0:0]         s_en, s_clr, s_flag;
    logic [DW-1:0]      s_thr;
    logic [3:0]         s_cnt_thr, s_period, s_cycle, s_cnt;
    logic               s_any;
    logic [1:0]         s_state;
    logic [DW:0]        s_p2p;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    osc_intl_mc #(.CH(CH), .DW(DW), .CW(CW)) dut (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_data_valid(valid),
        .i_osc_en(en), .i_clr(clr), .i_data_thresh(thr), .i_cnt_thresh(cnt_thr),
        .i_period(period), .i_cycle_cnt(cycle), .o_osc_flag(flag), .o_osc_any(any),
        .o_state(state), .o_osc_cnt(cnt), .o_p2p(p2p)
    );

    osc_intl_mc #(.CH(1), .DW(DW), .CW(4)) u_sat (
        .i_clk(clk), .i_rst(rst), .i_data(s_data), .i_data_valid(s_valid),
        .i_osc_en(s_en), .i_clr(s_clr), .i_data_thresh(s_thr), .i_cnt_thresh(s_cnt_thr),
        .i_period(s_period), .i_cycle_cnt(s_cycle), .o_osc_flag(s_flag), .o_osc_any(s_any),
        .o_state(s_state), .o_osc_cnt(s_cnt), .o_p2p(s_p2p)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] oc(input int c);
        return 32'(cnt[c*CW +: CW]);
    endfunction

    function automatic logic [31:0] pp(input int c);
        return 32'(p2p[c*(DW+1) +: (DW+1)]);
    endfunction

    // n valid samples; ch0 alternates a0/b0, ch1 alternates a1/b1, ch2/ch3 stay 0
    task automatic win(input int n, input int a0, input int b0, input int a1, input int b1);
        for (int i = 0; i < n; i++) begin
            data  = {40'd0, 20'((i % 2 != 0) ? b1 : a1), 20'((i % 2 != 0) ? b0 : a0)};
            valid = 1'b1;
            tick();
        end
        valid = 1'b0;
        data  = '0;
    endtask

    initial begin
        rst = 1'b1; data = '0; valid = 1'b0; en = '0; clr = '0;
        thr = {4{20'd1500}}; cnt_thr = 16'd3; period = 16'd8; cycle = 16'd0;
        s_data = '0; s_valid = 1'b0; s_en = 1'b0; s_clr = 1'b0; s_thr = 20'd1500;
        s_cnt_thr = 4'd15; s_period = 4'd2; s_cycle = 4'd0;
        tick(); tick();
        chk("rst_state", 32'(state), 0);
        chk("rst_flag", 32'(flag), 0);
        chk("rst_any", 32'(any), 0);
        chk("rst_cnt", 32'(|cnt), 0);
        chk("rst_p2p", 32'(|p2p), 0);

        rst = 1'b0; en = 4'hF;
        tick();
        chk("arm_run", 32'(state), 1);

        win(8, 1000, -1000, 1000, -1000);
        chk("w1_eval", 32'(state), 2);
        tick();
        chk("w1_p2p0", pp(0), 2000);
        chk("w1_cnt0", oc(0), 1);
        chk("w1_cnt1", oc(1), 1);
        win(8, 1000, -1000, 1000, -1000);
        tick();
        chk("w2_cnt0", oc(0), 2);
        chk("w2_cnt1", oc(1), 2);
        win(8, 1000, -1000, 777, 777);
        tick();
        chk("w3_cnt0", oc(0), 3);
        chk("w3_cnt1", oc(1), 1);
        chk("w3_p2p1", pp(1), 0);
        chk("w3_flag_t2", 32'(flag), 0);
        tick();
        chk("w3_flag_t3", 32'(flag), 1);
        chk("w3_any", 32'(any), 1);
        chk("w3_cnt2", oc(2), 0);
        chk("w3_cnt3", oc(3), 0);
        win(8, 1000, -1000, 777, 777);
        tick();
        chk("w4_cnt0_hold", oc(0), 3);
        chk("w4_cnt1", oc(1), 0);
        win(8, 1000, -1000, 777, 777);
        tick();
        chk("w5_cnt1", oc(1), 0);
        chk("w5_flag", 32'(flag), 1);

        clr = 4'b0001;
        tick();
        chk("clr_flag0", 32'(flag), 0);
        clr = '0;
        tick();
        chk("reset_flag1", 32'(flag), 1);

        win(3, 1000, -1000, 0, 0);
        rst = 1'b1;
        tick();
        chk("mid_rst_state", 32'(state), 0);
        chk("mid_rst_flag", 32'(flag), 0);
        chk("mid_rst_any", 32'(any), 0);
        chk("mid_rst_cnt", 32'(|cnt), 0);
        chk("mid_rst_p2p", 32'(|p2p), 0);

        rst = 1'b0; period = 16'd4; cycle = 16'd2;
        tick();
        win(4, 1000, -1000, 0, 0);
        tick();
        chk("fin1_state", 32'(state), 1);
        chk("fin1_cnt0", oc(0), 1);
        win(4, 1000, -1000, 0, 0);
        tick();
        chk("fin2_idle", 32'(state), 0);
        chk("fin2_cnt0", oc(0), 2);
        tick();
        chk("fin_restart", 32'(state), 1);
        chk("fin_cleared", oc(0), 0);
        win(4, 1000, -1000, 0, 0);
        tick();
        chk("fin_new_cnt0", oc(0), 1);
        chk("fin_new_state", 32'(state), 1);

        period = 16'd0; cycle = 16'd0;
        win(1, 12345, 12345, 0, 0);
        chk("per0_eval", 32'(state), 2);
        tick();
        chk("per0_p2p0", pp(0), 0);
        chk("per0_cnt0", oc(0), 0);

        period = 16'd2;
        win(2, -524288, 524287, 0, 0);
        tick();
        chk("ext_p2p0", pp(0), 1048575);

        valid = 1'b1;
        data = {60'd0, 20'd0};    tick();
        data = {60'd0, 20'd100};  tick();
        data = {60'd0, 20'd5000}; tick();
        valid = 1'b0;
        chk("evalv_p2p0", pp(0), 100);
        data = {60'd0, 20'd0}; valid = 1'b1;
        tick();
        chk("evalv_dropped", 32'(state), 1);
        data = {60'd0, 20'd300};
        tick();
        valid = 1'b0;
        chk("evalv_eval", 32'(state), 2);
        tick();
        chk("evalv_p2p_next", pp(0), 300);

        s_en = 1'b1; s_clr = 1'b1; s_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            s_data = 20'((i % 2 != 0) ? -1000 : 1000);
            tick();
        end
        chk("sat_cnt", 32'(s_cnt), 15);
        chk("sat_flag_held", 32'(s_flag), 0);
        s_clr = 1'b0; s_valid = 1'b0;
        tick();
        chk("sat_flag", 32'(s_flag), 1);
        chk("sat_any", 32'(s_any), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
